// File: rtl/pump_pkg.sv
// Shared types and constants for the peristaltic pump sequencer.
package pump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pump_state_e;

  localparam logic VALVE_CLOSED = 1'b1;

endpackage

// File: rtl/pump_phase_decode.sv
// Maps a step index to its open-valve mask: even step 2k opens valve k,
// odd step 2k+1 opens valves k and (k+1) mod NUM_VALVES.
module pump_phase_decode
  import pump_pkg::*;
#(
  parameter int NUM_VALVES = 3,
  parameter int STEP_W     = $clog2(2 * NUM_VALVES)
) (
  input  logic [STEP_W-1:0]     step,
  output logic [NUM_VALVES-1:0] open_mask
);

  localparam logic [STEP_W-2:0] K_LAST = (STEP_W - 1)'(NUM_VALVES - 1);

  logic [STEP_W-2:0] k;
  logic [STEP_W-2:0] k_next;

  always_comb begin
    k         = step[STEP_W-1:1];
    k_next    = (k == K_LAST) ? '0 : k + 1'b1;
    open_mask = '0;
    for (int i = 0; i < NUM_VALVES; i++) begin
      if (k == (STEP_W - 1)'(i)) begin
        open_mask[i] = 1'b1;
      end
      if (step[0] && (k_next == (STEP_W - 1)'(i))) begin
        open_mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peristaltic_pump_ctrl.sv
// Peristaltic pump valve sequencer: IDLE/RUN/DONE FSM stepping through 2N valve
// patterns per stroke. Optional sequencer freeze input enabled by PUMP_SEQ_HOLD_EN.
module peristaltic_pump_ctrl
  import pump_pkg::*;
#(
  parameter int NUM_VALVES = 3,
  parameter int DWELL_W    = 16,
  parameter int STROKE_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  dir,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [STROKE_W-1:0]   strokes,
`ifdef PUMP_SEQ_HOLD_EN
  input  logic                  hold,
`endif
  output logic [NUM_VALVES-1:0] valve_air,
  output logic                  busy,
  output logic                  done,
  output logic [STROKE_W-1:0]   stroke_cnt
);

  localparam int STEP_W = $clog2(2 * NUM_VALVES);
  localparam logic [STEP_W-1:0]     LAST_STEP  = STEP_W'(2 * NUM_VALVES - 1);
  localparam logic [NUM_VALVES-1:0] ALL_CLOSED = {NUM_VALVES{VALVE_CLOSED}};

  pump_state_e           state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [DWELL_W-1:0]    dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0]    dwell_lat_q, dwell_lat_d;
  logic [STROKE_W-1:0]   strokes_lat_q, strokes_lat_d;
  logic                  dir_q, dir_d;
  logic [STROKE_W-1:0]   stroke_cnt_q, stroke_cnt_d;
  logic [NUM_VALVES-1:0] valve_air_q, valve_air_d;

  logic                  freeze;
  logic                  step_end;
  logic                  wrap;
  logic [STROKE_W-1:0]   cnt_inc;
  logic [NUM_VALVES-1:0] open_mask;

`ifdef PUMP_SEQ_HOLD_EN
  assign freeze = hold;
`else
  assign freeze = 1'b0;
`endif

  // A latched dwell of zero behaves like one cycle per step.
  assign step_end = (dwell_lat_q == '0) || (dwell_cnt_q == dwell_lat_q - 1'b1);
  assign wrap     = dir_q ? (step_q == '0) : (step_q == LAST_STEP);
  assign cnt_inc  = (&stroke_cnt_q) ? stroke_cnt_q : stroke_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    dwell_cnt_d   = dwell_cnt_q;
    dwell_lat_d   = dwell_lat_q;
    strokes_lat_d = strokes_lat_q;
    dir_d         = dir_q;
    stroke_cnt_d  = stroke_cnt_q;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d       = RUN;
          step_d        = dir ? LAST_STEP : '0;
          dwell_cnt_d   = '0;
          dwell_lat_d   = dwell;
          strokes_lat_d = strokes;
          dir_d         = dir;
          stroke_cnt_d  = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!freeze) begin
          if (step_end) begin
            dwell_cnt_d = '0;
            if (dir_q) begin
              step_d = wrap ? LAST_STEP : step_q - 1'b1;
            end else begin
              step_d = wrap ? '0 : step_q + 1'b1;
            end
            if (wrap) begin
              stroke_cnt_d = cnt_inc;
              if ((strokes_lat_q != '0) && (cnt_inc == strokes_lat_q)) begin
                state_d = DONE;
              end
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  pump_phase_decode #(
    .NUM_VALVES(NUM_VALVES),
    .STEP_W    (STEP_W)
  ) u_decode (
    .step     (step_d),
    .open_mask(open_mask)
  );

  // Valves are driven from the upcoming step so the pattern lands with the state.
  always_comb begin
    valve_air_d = ALL_CLOSED;
    if (state_d == RUN) begin
      valve_air_d = ~open_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      step_q        <= '0;
      dwell_cnt_q   <= '0;
      dwell_lat_q   <= '0;
      strokes_lat_q <= '0;
      dir_q         <= 1'b0;
      stroke_cnt_q  <= '0;
      valve_air_q   <= ALL_CLOSED;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      dwell_cnt_q   <= dwell_cnt_d;
      dwell_lat_q   <= dwell_lat_d;
      strokes_lat_q <= strokes_lat_d;
      dir_q         <= dir_d;
      stroke_cnt_q  <= stroke_cnt_d;
      valve_air_q   <= valve_air_d;
    end
  end

  assign valve_air  = valve_air_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign stroke_cnt = stroke_cnt_q;

endmodule

// File: tb/tb_peristaltic_pump_ctrl.sv
// Scoreboard bench for peristaltic_pump_ctrl with 3- and 5-valve instances;
// the hold scenario is compiled in only with PUMP_SEQ_HOLD_EN.
module tb_peristaltic_pump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start3, stop3, dir3;
  logic [15:0] dwell3, strokes3;
  logic [2:0]  va3;
  logic        busy3, done3;
  logic [15:0] cnt3;
`ifdef PUMP_SEQ_HOLD_EN
  logic        hold3;
  logic        hold5;
`endif

  logic        start5, stop5, dir5;
  logic [15:0] dwell5, strokes5;
  logic [4:0]  va5;
  logic        busy5, done5;
  logic [15:0] cnt5;

  peristaltic_pump_ctrl #(.NUM_VALVES(3), .DWELL_W(16), .STROKE_W(16)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .start     (start3),
    .stop      (stop3),
    .dir       (dir3),
    .dwell     (dwell3),
    .strokes   (strokes3),
`ifdef PUMP_SEQ_HOLD_EN
    .hold      (hold3),
`endif
    .valve_air (va3),
    .busy      (busy3),
    .done      (done3),
    .stroke_cnt(cnt3)
  );

  peristaltic_pump_ctrl #(.NUM_VALVES(5), .DWELL_W(16), .STROKE_W(16)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .start     (start5),
    .stop      (stop5),
    .dir       (dir5),
    .dwell     (dwell5),
    .strokes   (strokes5),
`ifdef PUMP_SEQ_HOLD_EN
    .hold      (hold5),
`endif
    .valve_air (va5),
    .busy      (busy5),
    .done      (done5),
    .stroke_cnt(cnt5)
  );

  typedef struct {
    logic [4:0]  valve;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t q3[$];
  exp_t q5[$];
  int   checks   = 0;
  int   failures = 0;

  localparam int BIG = 1 << 20;

  // Hand-derived valve_air patterns per step (bit 0 = valve 0, 1 = closed).
  function automatic logic [2:0] tbl3(input int s);
    case (s)
      0:       tbl3 = 3'b110;
      1:       tbl3 = 3'b100;
      2:       tbl3 = 3'b101;
      3:       tbl3 = 3'b001;
      4:       tbl3 = 3'b011;
      default: tbl3 = 3'b010;
    endcase
  endfunction

  function automatic logic [4:0] tbl5(input int s);
    case (s)
      0:       tbl5 = 5'b11110;
      1:       tbl5 = 5'b11100;
      2:       tbl5 = 5'b11101;
      3:       tbl5 = 5'b11001;
      4:       tbl5 = 5'b11011;
      5:       tbl5 = 5'b10011;
      6:       tbl5 = 5'b10111;
      7:       tbl5 = 5'b00111;
      8:       tbl5 = 5'b01111;
      default: tbl5 = 5'b01110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int n, input exp_t e);
    if (n == 3) q3.push_back(e);
    else q5.push_back(e);
  endtask

  // Queue one record per expected RUN cycle, plus the DONE cycle when the run completes.
  task automatic push_seq(input int n, input int dwl, input int nstr, input bit rev,
                          input int limit, input int hold_at, input int hold_len);
    int   dwe;
    int   c;
    int   stroke;
    int   pos;
    int   s;
    exp_t e;
    dwe = (dwl == 0) ? 1 : dwl;
    c   = 0;
    for (int j = 0; j < 2000 && c < limit; j++) begin
      stroke = j / (2 * n);
      pos    = j % (2 * n);
      s      = rev ? (2 * n - 1 - pos) : pos;
      if (nstr > 0 && stroke >= nstr) break;
      for (int d = 0; d < dwe && c < limit; d++) begin
        e.valve = (n == 3) ? {2'b00, tbl3(s)} : tbl5(s);
        e.done  = 1'b0;
        e.cnt   = 16'(stroke);
        c++;
        push_exp(n, e);
        if (c == hold_at) begin
          for (int h = 0; h < hold_len; h++) push_exp(n, e);
        end
      end
    end
    if (nstr > 0 && c < limit) begin
      e.valve = (n == 3) ? 5'b00111 : 5'b11111;
      e.done  = 1'b1;
      e.cnt   = 16'(nstr);
      push_exp(n, e);
    end
  endtask

  exp_t m3;
  always @(negedge clk) begin
    if (busy3 || done3) begin
      checks++;
      if (q3.size() == 0) begin
        failures++;
        $display("[TB] FAIL n3_unexpected actual=va%b busy%b done%b cnt%0d required=no activity",
                 va3, busy3, done3, cnt3);
      end else begin
        m3 = q3.pop_front();
        if (va3 !== m3.valve[2:0] || busy3 !== !m3.done || done3 !== m3.done || cnt3 !== m3.cnt) begin
          failures++;
          $display("[TB] FAIL n3_output actual=va%b busy%b done%b cnt%0d required=va%b busy%b done%b cnt%0d",
                   va3, busy3, done3, cnt3, m3.valve[2:0], !m3.done, m3.done, m3.cnt);
        end
      end
    end
  end

  exp_t m5;
  int   open5;
  always @(negedge clk) begin
    if (busy5 || done5) begin
      checks++;
      if (q5.size() == 0) begin
        failures++;
        $display("[TB] FAIL n5_unexpected actual=va%b busy%b done%b cnt%0d required=no activity",
                 va5, busy5, done5, cnt5);
      end else begin
        m5 = q5.pop_front();
        if (va5 !== m5.valve || busy5 !== !m5.done || done5 !== m5.done || cnt5 !== m5.cnt) begin
          failures++;
          $display("[TB] FAIL n5_output actual=va%b busy%b done%b cnt%0d required=va%b busy%b done%b cnt%0d",
                   va5, busy5, done5, cnt5, m5.valve, !m5.done, m5.done, m5.cnt);
        end
      end
      if (busy5) begin
        open5 = 0;
        for (int i = 0; i < 5; i++) if (va5[i] == 1'b0) open5++;
        checks++;
        if (open5 < 1 || open5 > 2) begin
          failures++;
          $display("[TB] FAIL n5_open_count actual=%0d required=1..2", open5);
        end
      end
    end
  end

  task automatic start_pump3(input logic [15:0] dwl, input logic [15:0] str, input logic d);
    @(negedge clk);
    dwell3 = dwl; strokes3 = str; dir3 = d; start3 = 1'b1;
  endtask

  task automatic drain(input string name, input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      start3 = 1'b0;
      start5 = 1'b0;
      if ((n == 3 ? q3.size() : q5.size()) == 0) break;
    end
    check({name, "_drained"}, 32'(n == 3 ? q3.size() : q5.size()), 32'd0);
    if (n == 3) q3.delete();
    else q5.delete();
  endtask

  task automatic check_idle3(input string name, input logic [15:0] cnt);
    check({name, "_valve"}, 32'(va3), 32'h7);
    check({name, "_busy"},  32'(busy3), 32'd0);
    check({name, "_done"},  32'(done3), 32'd0);
    check({name, "_cnt"},   32'(cnt3), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1;
    start3 = 0; stop3 = 0; dir3 = 0; dwell3 = 0; strokes3 = 0;
    start5 = 0; stop5 = 0; dir5 = 0; dwell5 = 0; strokes5 = 0;
`ifdef PUMP_SEQ_HOLD_EN
    hold3 = 0; hold5 = 0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle3("reset3", 16'd0);
    check("reset5_valve", 32'(va5), 32'h1f);
    check("reset5_cnt", 32'(cnt5), 32'd0);

    // Forward, dwell 2, one stroke.
    push_seq(3, 2, 1, 1'b0, BIG, 0, 0);
    start_pump3(16'd2, 16'd1, 1'b0);
    drain("fwd_d2", 3, 40);
    @(negedge clk);
    check_idle3("fwd_d2_after", 16'd1);

    // Reverse, dwell 0 treated as 1, two strokes.
    push_seq(3, 0, 2, 1'b1, BIG, 0, 0);
    start_pump3(16'd0, 16'd2, 1'b1);
    drain("rev_d0", 3, 40);
    @(negedge clk);
    check_idle3("rev_d0_after", 16'd2);

    // Continuous mode stopped in RUN cycle 20.
    push_seq(3, 1, 0, 1'b0, 20, 0, 0);
    start_pump3(16'd1, 16'd0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start3 = 1'b0;
      if (i == 20) stop3 = 1'b1;
    end
    @(negedge clk);
    stop3 = 1'b0;
    check("cont_stop_drained", 32'(q3.size()), 32'd0);
    check_idle3("cont_stop_after", 16'd3);
    repeat (3) @(negedge clk);

    // Stop coinciding with the final wrap wins over done.
    push_seq(3, 1, 1, 1'b0, 6, 0, 0);
    start_pump3(16'd1, 16'd1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) start3 = 1'b0;
      if (i == 6) stop3 = 1'b1;
    end
    @(negedge clk);
    stop3 = 1'b0;
    check("stop_prio_drained", 32'(q3.size()), 32'd0);
    check_idle3("stop_prio_after", 16'd0);
    repeat (2) @(negedge clk);

    // start together with stop in IDLE does not launch.
    @(negedge clk);
    start3 = 1'b1; stop3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0; stop3 = 1'b0;
    check_idle3("start_stop_idle", 16'd0);

    // Start pulses and input changes during RUN are ignored; reset mid-step.
    push_seq(3, 3, 0, 1'b0, 11, 0, 0);
    start_pump3(16'd3, 16'd0, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 1) start3 = 1'b0;
      if (i == 3) begin
        start3 = 1'b1; dir3 = 1'b1; dwell3 = 16'd7; strokes3 = 16'd1;
      end
      if (i == 4) start3 = 1'b0;
      if (i == 11) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_drained", 32'(q3.size()), 32'd0);
    check_idle3("rst_mid_after", 16'd0);
    q3.delete();

    // Five valves, dwell 3, one stroke.
    push_seq(5, 3, 1, 1'b0, BIG, 0, 0);
    @(negedge clk);
    dwell5 = 16'd3; strokes5 = 16'd1; dir5 = 1'b0; start5 = 1'b1;
    drain("n5_d3", 5, 60);
    @(negedge clk);
    check("n5_after_valve", 32'(va5), 32'h1f);
    check("n5_after_cnt", 32'(cnt5), 32'd1);

`ifdef PUMP_SEQ_HOLD_EN
    // Hold for five cycles starting at RUN cycle 5.
    push_seq(3, 2, 1, 1'b0, BIG, 5, 5);
    start_pump3(16'd2, 16'd1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) start3 = 1'b0;
      if (i == 5) hold3 = 1'b1;
      if (i == 10) hold3 = 1'b0;
    end
    drain("hold", 3, 40);
    @(negedge clk);
    check_idle3("hold_after", 16'd1);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
